// File: rtl/stream_shell_pkg.sv
// Shared FloPoCo exception-field encodings and the IEEE-754 single classifier
// used by the stream shell when STREAM_SHELL_FPC_CLASSIFY_EN is defined.
package stream_shell_pkg;

  localparam int FPC_EFW = 2;

  localparam logic [FPC_EFW-1:0] FPC_ZERO   = 2'b00;
  localparam logic [FPC_EFW-1:0] FPC_NORMAL = 2'b01;
  localparam logic [FPC_EFW-1:0] FPC_INF    = 2'b10;
  localparam logic [FPC_EFW-1:0] FPC_NAN    = 2'b11;

  // Denormals (exp==0, mantissa!=0) are tagged zero; the word itself is untouched.
  function automatic logic [FPC_EFW-1:0] fpc_classify(input logic [31:0] word);
    logic [7:0]  exp_f;
    logic [22:0] man_f;
    logic        unused_sign;
    exp_f       = word[30:23];
    man_f       = word[22:0];
    unused_sign = word[31];
    if (exp_f == 8'd0)
      return FPC_ZERO;
    else if (exp_f == 8'hFF)
      return (man_f == 23'd0) ? FPC_INF : FPC_NAN;
    else
      return FPC_NORMAL;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer with a registered upstream ready; ready drops only
// when both entries are occupied, so an accepted beat is never dropped.
module stream_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_cnt;
  logic         r_rdy;

  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_cnt_nxt;

  assign o_ready   = r_rdy;
  assign o_valid   = (r_cnt != 2'd0);
  assign o_data    = r_mem[r_rptr];
  assign w_push    = i_valid & r_rdy;
  assign w_pop     = o_valid & i_ready;
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
      r_rdy    <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop)
        r_rptr <= ~r_rptr;
      r_cnt <= w_cnt_nxt;
      // Ready is computed from next occupancy so it can be a plain flop.
      r_rdy <= (w_cnt_nxt <= 2'd1);
    end
  end

endmodule

// File: rtl/stream_shell_joinfork.sv
// Stream shell: joins NIN skid-buffered inputs into one kernel beat (tagging
// each word with a FloPoCo exception field) and forks the kernel output to
// NOUT outputs. Tagging is IEEE-754 classified when STREAM_SHELL_FPC_CLASSIFY_EN
// is defined, otherwise every word is tagged normal.
module stream_shell_joinfork
  import stream_shell_pkg::*;
#(
  parameter int STREAMW = 32,
  parameter int NIN     = 4,
  parameter int NOUT    = 4,
  parameter int CNTW    = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NIN-1:0]                    in_valid,
  output logic [NIN-1:0]                    in_ready,
  input  logic [NIN*STREAMW-1:0]            in_data,
  output logic                              k_ivalid,
  input  logic                              k_iready,
  output logic [NIN*(STREAMW+FPC_EFW)-1:0]  k_idata,
  input  logic                              k_ovalid,
  output logic                              k_oready,
  input  logic [NOUT*(STREAMW+FPC_EFW)-1:0] k_odata,
  output logic [NOUT-1:0]                   out_valid,
  input  logic [NOUT-1:0]                   out_ready,
  output logic [NOUT*STREAMW-1:0]           out_data,
  output logic [CNTW-1:0]                   in_count,
  output logic [CNTW-1:0]                   out_count
);

  localparam int              KW      = STREAMW + FPC_EFW;
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic [NIN-1:0]          w_buf_vld;
  logic [NIN*STREAMW-1:0]  w_buf_dat;
  logic                    w_join;

  logic                    r_full;
  logic [NOUT-1:0]         r_sent;
  logic [NOUT*STREAMW-1:0] r_data;
  logic [CNTW-1:0]         r_in_cnt;
  logic [CNTW-1:0]         r_out_cnt;

  logic [NOUT-1:0]         w_out_hs;
  logic                    w_done;
  logic                    w_load;
  logic [NOUT*STREAMW-1:0] w_kdat_lo;
  logic [NOUT*FPC_EFW-1:0] w_kdat_ef;
  logic                    w_unused_ef;

  assign k_ivalid = &w_buf_vld;
  assign w_join   = k_ivalid & k_iready;

  for (genvar i = 0; i < NIN; i++) begin : g_in
    logic [FPC_EFW-1:0] w_ef;

    stream_skid_buf #(.W(STREAMW)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_valid (in_valid[i]),
      .o_ready (in_ready[i]),
      .i_data  (in_data[i*STREAMW +: STREAMW]),
      .o_valid (w_buf_vld[i]),
      .i_ready (w_join),
      .o_data  (w_buf_dat[i*STREAMW +: STREAMW])
    );

`ifdef STREAM_SHELL_FPC_CLASSIFY_EN
    assign w_ef = fpc_classify(w_buf_dat[i*STREAMW +: 32]);
`else
    assign w_ef = FPC_NORMAL;
`endif

    assign k_idata[i*KW +: KW] = {w_ef, w_buf_dat[i*STREAMW +: STREAMW]};
  end

  // Output words drop the exception field; it has no meaning downstream.
  for (genvar j = 0; j < NOUT; j++) begin : g_out
    assign w_kdat_lo[j*STREAMW +: STREAMW] = k_odata[j*KW +: STREAMW];
    assign w_kdat_ef[j*FPC_EFW +: FPC_EFW] = k_odata[j*KW+STREAMW +: FPC_EFW];
  end
  assign w_unused_ef = ^w_kdat_ef;

  assign out_valid = {NOUT{r_full}} & ~r_sent;
  assign out_data  = r_data;
  assign w_out_hs  = out_valid & out_ready;
  assign w_done    = r_full & (&(r_sent | w_out_hs));
  assign k_oready  = ~r_full | w_done;
  assign w_load    = k_ovalid & k_oready;
  assign in_count  = r_in_cnt;
  assign out_count = r_out_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full    <= 1'b0;
      r_sent    <= '0;
      r_data    <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_load) begin
        r_data <= w_kdat_lo;
        r_full <= 1'b1;
        r_sent <= '0;
      end else if (w_done) begin
        r_full <= 1'b0;
        r_sent <= '0;
      end else begin
        r_sent <= r_sent | w_out_hs;
      end
      if (w_join)
        r_in_cnt <= r_in_cnt + CNT_ONE;
      if (w_done)
        r_out_cnt <= r_out_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_stream_shell_joinfork.sv
// Self-checking bench for stream_shell_joinfork: queue-based reference model of
// the join, the per-channel fork and the FloPoCo tagging rules.
module tb_stream_shell_joinfork;

  localparam int W  = 32;
  localparam int NI = 4;
  localparam int NO = 4;
  localparam int KW = W + 2;

  logic              clk;
  logic              rst;
  logic [NI-1:0]     in_valid;
  logic [NI-1:0]     in_ready;
  logic [NI*W-1:0]   in_data;
  logic              k_ivalid;
  logic              k_iready;
  logic [NI*KW-1:0]  k_idata;
  logic              k_ovalid;
  logic              k_oready;
  logic [NO*KW-1:0]  k_odata;
  logic [NO-1:0]     out_valid;
  logic [NO-1:0]     out_ready;
  logic [NO*W-1:0]   out_data;
  logic [31:0]       in_count;
  logic [31:0]       out_count;

  int errors;
  int checks;

  logic [W-1:0]     src_in  [NI][$];
  logic [W-1:0]     mq      [NI][$];
  logic [NI*KW-1:0] exp_join[$];
  logic [NI*KW-1:0] act_join[$];
  logic [NO*KW-1:0] src_ko  [$];
  logic [W-1:0]     exp_out [NO][$];
  logic [W-1:0]     act_out [NO][$];
  int               taken   [NO];
  int               in_exp;
  logic [NI-1:0]    en_in;
  logic             ko_en;

  stream_shell_joinfork #(.STREAMW(W), .NIN(NI), .NOUT(NO), .CNTW(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .k_ivalid(k_ivalid), .k_iready(k_iready), .k_idata(k_idata),
    .k_ovalid(k_ovalid), .k_oready(k_oready), .k_odata(k_odata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_count(in_count), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] ref_tag(input logic [31:0] w);
`ifdef STREAM_SHELL_FPC_CLASSIFY_EN
    logic [7:0]  e;
    logic [22:0] m;
    e = w[30:23];
    m = w[22:0];
    if (e == 8'd0) return 2'b00;
    if (e == 8'd255) return (m == 23'd0) ? 2'b10 : 2'b11;
    return 2'b01;
`else
    return 2'b01;
`endif
  endfunction

  function automatic logic [NO*KW-1:0] rand_kbeat();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[NO*KW-1:0];
  endfunction

  function automatic int min_taken();
    int m;
    m = taken[0];
    for (int j = 1; j < NO; j++) if (taken[j] < m) m = taken[j];
    return m;
  endfunction

  // Counts differences between recorded and expected joined beats, then clears both.
  function automatic int joins_diff();
    int n;
    n = (act_join.size() != exp_join.size()) ? 1 : 0;
    for (int k = 0; k < act_join.size() && k < exp_join.size(); k++)
      if (act_join[k] !== exp_join[k]) n++;
    act_join.delete();
    exp_join.delete();
    return n;
  endfunction

  function automatic int outs_diff();
    int n;
    n = 0;
    for (int j = 0; j < NO; j++) begin
      if (act_out[j].size() != exp_out[j].size()) n++;
      for (int k = 0; k < act_out[j].size() && k < exp_out[j].size(); k++)
        if (act_out[j][k] !== exp_out[j][k]) n++;
      act_out[j].delete();
      exp_out[j].delete();
    end
    return n;
  endfunction

  function automatic bit all_drained();
    bit d;
    d = (src_ko.size() == 0);
    for (int i = 0; i < NI; i++) if (src_in[i].size() != 0 || mq[i].size() != 0) d = 0;
    for (int j = 0; j < NO; j++) if (act_out[j].size() != exp_out[j].size()) d = 0;
    return d;
  endfunction

  // One clock: drive sources, record handshakes into the model, advance.
  task automatic tick();
    logic [NI*KW-1:0] b;
    bit avail;
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = en_in[i] && (src_in[i].size() > 0);
      in_data[i*W +: W] = (src_in[i].size() > 0) ? src_in[i][0] : '0;
    end
    k_ovalid = ko_en && (src_ko.size() > 0);
    k_odata  = (src_ko.size() > 0) ? src_ko[0] : '0;
    #1;
    avail = 1;
    for (int i = 0; i < NI; i++) if (mq[i].size() == 0) avail = 0;
    if (avail && k_iready) begin
      for (int i = 0; i < NI; i++) begin
        b[i*KW +: KW] = {ref_tag(mq[i][0]), mq[i][0]};
        void'(mq[i].pop_front());
      end
      exp_join.push_back(b);
      in_exp++;
    end
    if (k_ivalid && k_iready) act_join.push_back(k_idata);
    for (int i = 0; i < NI; i++)
      if (in_valid[i] && in_ready[i]) mq[i].push_back(src_in[i].pop_front());
    for (int j = 0; j < NO; j++)
      if (out_valid[j] && out_ready[j]) begin
        act_out[j].push_back(out_data[j*W +: W]);
        taken[j]++;
      end
    if (k_ovalid && k_oready) begin
      for (int j = 0; j < NO; j++) exp_out[j].push_back(src_ko[0][j*KW +: W]);
      void'(src_ko.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin src_in[i].delete(); mq[i].delete(); end
    for (int j = 0; j < NO; j++) begin exp_out[j].delete(); act_out[j].delete(); taken[j] = 0; end
    src_ko.delete(); exp_join.delete(); act_join.delete();
    in_exp = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL rst_in_ready got=%h want=0", in_ready); end
    checks++; if (k_ivalid !== 1'b0) begin errors++; $display("FAIL rst_k_ivalid got=%b want=0", k_ivalid); end
    checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL rst_out_valid got=%h want=0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data got=%h want=0", out_data); end
    checks++; if (in_count !== 0 || out_count !== 0) begin errors++; $display("FAIL rst_counts got=%0d/%0d want=0/0", in_count, out_count); end
    checks++; if (k_oready !== 1'b1) begin errors++; $display("FAIL rst_k_oready got=%b want=1", k_oready); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 4'hF) begin errors++; $display("FAIL post_rst_in_ready got=%h want=f", in_ready); end
  endtask

  task automatic test_skew_join();
    int t[NI] = '{0, 3, 5, 9};
    logic [W-1:0] wv[NI] = '{32'h3F800000, 32'h40000000, 32'hC0490FDB, 32'h7F800000};
    logic [NI*KW-1:0] want;
    k_iready = 0;
    for (int i = 0; i < NI; i++) src_in[i].push_back(wv[i]);
    for (int c = 0; c <= 9; c++) begin
      for (int i = 0; i < NI; i++) en_in[i] = (t[i] == c);
      tick();
      checks++;
      if (k_ivalid !== (c == 9)) begin errors++; $display("FAIL skew_k_ivalid cyc=%0d got=%b want=%b", c, k_ivalid, (c == 9)); end
    end
    en_in = '0;
    for (int i = 0; i < NI; i++) want[i*KW +: KW] = {ref_tag(wv[i]), wv[i]};
    checks++; if (k_idata !== want) begin errors++; $display("FAIL skew_k_idata got=%h want=%h", k_idata, want); end
    k_iready = 1;
    tick();
    k_iready = 0;
    checks++; if (in_count !== 1) begin errors++; $display("FAIL skew_in_count got=%0d want=1", in_count); end
    checks++; if (k_ivalid !== 1'b0) begin errors++; $display("FAIL skew_after_pop k_ivalid got=%b want=0", k_ivalid); end
    checks++; if (joins_diff() !== 0) begin errors++; $display("FAIL skew_join_model mismatch got=diff want=0"); end
  endtask

  task automatic test_backpressure();
    int base;
    base = in_exp;
    k_iready = 0;
    for (int k = 0; k < 3; k++) src_in[0].push_back(32'h1000_0000 + k);
    en_in = 4'b0001;
    repeat (4) tick();
    checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready0 got=%b want=0", in_ready[0]); end
    checks++; if (src_in[0].size() != 1) begin errors++; $display("FAIL bp_accepted got=%0d want=2", 3 - src_in[0].size()); end
    for (int i = 1; i < NI; i++)
      for (int k = 0; k < 3; k++) src_in[i].push_back($urandom);
    en_in = 4'hF;
    k_iready = 1;
    for (int c = 0; c < 30 && !all_drained(); c++) tick();
    checks++; if (!all_drained()) begin errors++; $display("FAIL bp_drain_timeout got=pending want=empty"); end
    checks++; if (in_exp - base != 3) begin errors++; $display("FAIL bp_join_count got=%0d want=3", in_exp - base); end
    checks++; if (joins_diff() !== 0) begin errors++; $display("FAIL bp_order got=mismatch want=in-order"); end
    checks++; if (in_count !== in_exp) begin errors++; $display("FAIL bp_in_count got=%0d want=%0d", in_count, in_exp); end
    k_iready = 0;
    en_in = '0;
  endtask

  task automatic test_uneven_fork();
    src_ko.push_back(rand_kbeat());
    src_ko.push_back(rand_kbeat());
    ko_en = 1;
    out_ready = 4'b0101;
    tick();
    checks++; if (out_valid !== 4'hF) begin errors++; $display("FAIL fork_load got=%h want=f", out_valid); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (k_oready !== 1'b0) begin errors++; $display("FAIL fork_partial_k_oready cyc=%0d got=%b want=0", c, k_oready); end
    end
    checks++; if (out_valid !== 4'b1010) begin errors++; $display("FAIL fork_partial_valid got=%h want=a", out_valid); end
    checks++; if (out_count !== 0) begin errors++; $display("FAIL fork_partial_count got=%0d want=0", out_count); end
    out_ready = 4'b1010;
    #1;
    checks++; if (k_oready !== 1'b1) begin errors++; $display("FAIL fork_done_k_oready got=%b want=1", k_oready); end
    tick();
    checks++; if (out_count !== 1) begin errors++; $display("FAIL fork_out_count got=%0d want=1", out_count); end
    checks++; if (out_valid !== 4'hF) begin errors++; $display("FAIL fork_b2b_valid got=%h want=f", out_valid); end
    out_ready = 4'hF;
    for (int c = 0; c < 10 && !all_drained(); c++) tick();
    checks++; if (out_count !== min_taken()) begin errors++; $display("FAIL fork_final_count got=%0d want=%0d", out_count, min_taken()); end
    checks++; if (outs_diff() !== 0) begin errors++; $display("FAIL fork_data got=mismatch want=match"); end
    ko_en = 0;
  endtask

  task automatic test_streaming();
    int ib, ob, cyc;
    ib = in_exp;
    ob = min_taken();
    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < NI; i++) src_in[i].push_back($urandom);
      src_ko.push_back(rand_kbeat());
    end
    en_in = 4'hF; ko_en = 1; k_iready = 1; out_ready = 4'hF;
    cyc = 0;
    while (cyc < 200 && !all_drained()) begin tick(); cyc++; end
    checks++; if (cyc > 102) begin errors++; $display("FAIL stream_cycles got=%0d want<=102", cyc); end
    checks++; if (in_exp - ib != 100) begin errors++; $display("FAIL stream_joins got=%0d want=100", in_exp - ib); end
    checks++; if (min_taken() - ob != 100) begin errors++; $display("FAIL stream_forks got=%0d want=100", min_taken() - ob); end
    checks++; if (in_count !== in_exp) begin errors++; $display("FAIL stream_in_count got=%0d want=%0d", in_count, in_exp); end
    checks++; if (out_count !== min_taken()) begin errors++; $display("FAIL stream_out_count got=%0d want=%0d", out_count, min_taken()); end
    checks++; if (joins_diff() !== 0) begin errors++; $display("FAIL stream_join_data got=mismatch want=match"); end
    checks++; if (outs_diff() !== 0) begin errors++; $display("FAIL stream_out_data got=mismatch want=match"); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 150; k++) begin
      for (int i = 0; i < NI; i++) src_in[i].push_back($urandom);
      src_ko.push_back(rand_kbeat());
    end
    for (int c = 0; c < 400; c++) begin
      en_in = 4'($urandom);
      ko_en = $urandom_range(0, 1);
      k_iready = $urandom_range(0, 1);
      out_ready = 4'($urandom);
      tick();
    end
    en_in = 4'hF; ko_en = 1; k_iready = 1; out_ready = 4'hF;
    for (int c = 0; c < 400 && !all_drained(); c++) tick();
    checks++; if (!all_drained()) begin errors++; $display("FAIL rand_drain_timeout got=pending want=empty"); end
    checks++; if (in_count !== in_exp) begin errors++; $display("FAIL rand_in_count got=%0d want=%0d", in_count, in_exp); end
    checks++; if (out_count !== min_taken()) begin errors++; $display("FAIL rand_out_count got=%0d want=%0d", out_count, min_taken()); end
    checks++; if (joins_diff() !== 0) begin errors++; $display("FAIL rand_join_data got=mismatch want=match"); end
    checks++; if (outs_diff() !== 0) begin errors++; $display("FAIL rand_out_data got=mismatch want=match"); end
  endtask

  task automatic test_classify();
    logic [W-1:0] wv[8] = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h40490FDB,
                            32'h00000001, 32'hFF800000, 32'h3F800000, 32'hFFFFFFFF};
`ifdef STREAM_SHELL_FPC_CLASSIFY_EN
    logic [1:0] tg[8] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b01, 2'b11};
`else
    logic [1:0] tg[8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`endif
    logic [NI*KW-1:0] beat;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NI; i++) src_in[i].push_back(wv[b*NI + i]);
    en_in = 4'hF; k_iready = 1;
    for (int c = 0; c < 20 && !all_drained(); c++) tick();
    checks++; if (act_join.size() != 2) begin errors++; $display("FAIL fpc_beats got=%0d want=2", act_join.size()); end
    for (int b = 0; b < 2 && b < act_join.size(); b++) begin
      beat = act_join[b];
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (beat[i*KW +: KW] !== {tg[b*NI + i], wv[b*NI + i]})
          begin errors++; $display("FAIL fpc_tag word=%h got=%h want=%h", wv[b*NI + i], beat[i*KW +: KW], {tg[b*NI + i], wv[b*NI + i]}); end
      end
    end
    void'(joins_diff());
    en_in = '0; k_iready = 0;
  endtask

  task automatic test_reset_mid();
    k_iready = 0; out_ready = '0;
    src_in[0].push_back(32'hDEAD0001);
    src_in[0].push_back(32'hDEAD0002);
    en_in = 4'b0001;
    src_ko.push_back(rand_kbeat());
    ko_en = 1;
    repeat (3) tick();
    checks++; if (out_valid !== 4'hF) begin errors++; $display("FAIL rstmid_pre_full got=%h want=f", out_valid); end
    rst = 1'b1;
    en_in = '0; ko_en = 0;
    #2;
    checks++; if (out_valid !== 4'h0 || k_ivalid !== 1'b0 || in_ready !== 4'h0) begin errors++; $display("FAIL rstmid_valids got=%h/%b/%h want=0/0/0", out_valid, k_ivalid, in_ready); end
    checks++; if (in_count !== 0 || out_count !== 0) begin errors++; $display("FAIL rstmid_counts got=%0d/%0d want=0/0", in_count, out_count); end
    model_clear();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) src_in[i].push_back(32'h0BEEF000 + i);
    src_ko.push_back(rand_kbeat());
    en_in = 4'hF; ko_en = 1; k_iready = 1; out_ready = 4'hF;
    for (int c = 0; c < 10 && !all_drained(); c++) tick();
    checks++; if (in_count !== 1 || out_count !== 1) begin errors++; $display("FAIL rstmid_fresh_counts got=%0d/%0d want=1/1", in_count, out_count); end
    checks++; if (joins_diff() !== 0) begin errors++; $display("FAIL rstmid_stale_join got=mismatch want=fresh"); end
    checks++; if (outs_diff() !== 0) begin errors++; $display("FAIL rstmid_stale_out got=mismatch want=fresh"); end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1;
    in_valid = '0; in_data = '0; k_iready = 0; k_ovalid = 0; k_odata = '0; out_ready = '0;
    en_in = '0; ko_en = 0;
    model_clear();
    test_reset();
    test_skew_join();
    test_backpressure();
    test_uneven_fork();
    test_streaming();
    test_classify();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_shell_joinfork.md
Name: stream_shell_joinfork

Overview:
- Parametrised top-level stream shell; the next generation of the generated single-kernel top.
- Joins NIN independent external input streams into one kernel input beat, each with its own valid/ready.
- Appends the FloPoCo 2-bit exception field to each input word and strips it from each output word.
- Forks the kernel output beat to NOUT independent output streams, each with its own oready, and counts completed transactions.

Parameters:
- STREAMW, 32: external word width per channel.
- NIN, 4: number of input channels, 1..16.
- NOUT, 4: number of output channels, 1..16.
- CNTW, 32: width of the transaction counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  NIN  per-channel input valid
- in_ready  out  NIN  per-channel input ready
- in_data  in  NIN*STREAMW  input words; channel i occupies bits [i*STREAMW +: STREAMW]
- k_ivalid  out  1  kernel input valid
- k_iready  in  1  kernel input ready
- k_idata  out  NIN*(STREAMW+2)  kernel input words; each is {fpc_ef[1:0], word}
- k_ovalid  in  1  kernel output valid
- k_oready  out  1  kernel output ready
- k_odata  in  NOUT*(STREAMW+2)  kernel output words, FloPoCo format
- out_valid  out  NOUT  per-channel output valid
- out_ready  in  NOUT  per-channel output ready
- out_data  out  NOUT*STREAMW  output words, low STREAMW bits of each kernel word
- in_count  out  CNTW  number of joined beats accepted by the kernel
- out_count  out  CNTW  number of fully forked output beats

Behaviour:
- Reset (async assert; deassert synchronous to clk):
  - all skid buffers and the fork stage empty; sent flags cleared; counters 0.
  - in_ready=0, k_ivalid=0, out_valid=0, out_data=0.
- Input side: each channel has a 2-entry skid buffer (stream_skid_buf).
  - in_ready[i] is registered and is 1 when the buffer holds at most 1 entry.
  - A beat is accepted when in_valid[i] & in_ready[i].
  - A full buffer never drops or overwrites data.
- Join:
  - k_ivalid = AND of all buffers being non-empty.
  - When k_ivalid & k_iready, every buffer pops its head in the same cycle and in_count increments.
  - A simultaneous push and pop on a 1-entry buffer keeps occupancy at 1.
- Latency: from in_valid&in_ready to k_ivalid is at least 1 cycle. Channels may arrive in any order and at any skew.
- Fork stage: a single registered beat with sent[NOUT] flags.
  - out_valid[j] = full & ~sent[j].
  - Channel j completes on out_valid[j] & out_ready[j].
  - done_now = full & all(sent | (out_valid & out_ready)).
  - k_oready = ~full | done_now.
  - On done_now: out_count increments and sent clears. If k_ovalid is high the same cycle, the new beat loads back-to-back; otherwise the stage empties.
  - A channel that has completed never re-asserts valid for the same beat.
- Kernel-to-output latency: 1 cycle. Sustained throughput is 1 beat/cycle when all out_ready are high.
- Counters wrap modulo 2^CNTW with no saturation.
- Reset mid-transfer drops all buffered beats.

Optional Feature:
- Macro: STREAM_SHELL_FPC_CLASSIFY_EN.
- Defined: fpc_ef is derived per word from its IEEE-754 single encoding; requires STREAMW=32.
  - exp=0 -> 2'b00. Denormals are flushed: the word is forwarded unchanged but tagged zero.
  - exp=255, mantissa=0 -> 2'b10.
  - exp=255, mantissa!=0 -> 2'b11.
  - otherwise -> 2'b01.
- Undefined: fpc_ef is the constant 2'b01 for every word.

Decomposition:
- Package stream_shell_pkg holds:
  - FPC_ZERO=2'b00, FPC_NORMAL=2'b01, FPC_INF=2'b10, FPC_NAN=2'b11.
  - the FPC_EFW=2 width constant.
  - the fpc_classify function.
- Sub-module stream_skid_buf: parameter W, 2-entry, ports clk, rst, valid/ready/data on both sides. Instantiated NIN times.

Test Plan:
- Skewed join, NIN=4: channel 0 gets 0x3F800000 at t0, ch1 at t3, ch2 at t5, ch3 at t9. k_ivalid must first rise the cycle after t9, and k_idata must carry all four words; in_count must reach 1.
- Backpressure: hold k_iready=0 and drive 3 beats on ch0. in_ready[0] must fall after 2 accepted beats with no data loss. Release k_iready: beats must pop in order.
- Uneven fork: k_odata beat A, out_ready=4'b0101 for 3 cycles, then 4'b1010. Channels 0 and 2 must take A first; A must be held until channels 1 and 3 take it. out_count=1, and k_oready must be 0 while the stage is partial.
- Streaming: 100 beats, all readies high. in_count=out_count=100 and one beat per cycle after fill.
- FPC classify with the macro on: inputs 0x00000000, 0x7F800000, 0x7FC00000, 0x40490FDB. Tags must be 00, 10, 11, 01. Macro off: all tags 01.
- Assert rst with 2 buffered inputs and the fork stage full. All valids must drop and counters read 0. The first beat after reset must not be a stale word.
